// File: rtl/gpr_wb_arb_if.sv
// Write-back bus between the two requesters, the read-compare ports and the
// register-file write port. The arbiter uses the slave view.
interface gpr_wb_arb_if #(
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32
);
    logic                  a_req_;
    logic [REG_ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0]     a_data;
    logic                  a_stall_;
    logic                  b_req_;
    logic [REG_ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0]     b_data;
    logic                  b_stall_;
    logic [REG_ADDR_W-1:0] rd_addr_0;
    logic [REG_ADDR_W-1:0] rd_addr_1;
    logic                  fwd_hit_0_;
    logic                  fwd_hit_1_;
    logic [DATA_W-1:0]     fwd_data_0;
    logic [DATA_W-1:0]     fwd_data_1;
    logic                  we_;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic                  idle;

    modport master (
        output a_req_, a_addr, a_data, b_req_, b_addr, b_data, rd_addr_0, rd_addr_1,
        input  a_stall_, b_stall_, fwd_hit_0_, fwd_hit_1_, fwd_data_0, fwd_data_1,
               we_, wr_addr, wr_data, idle
    );

    modport slave (
        input  a_req_, a_addr, a_data, b_req_, b_addr, b_data, rd_addr_0, rd_addr_1,
        output a_stall_, b_stall_, fwd_hit_0_, fwd_hit_1_, fwd_data_0, fwd_data_1,
               we_, wr_addr, wr_data, idle
    );
endinterface

// File: rtl/gpr_wb_arb.sv
// Register-file write-port arbiter: port A has priority, losing port-B writes
// queue in a small FIFO with squash, forwarding compares and a starvation limit.
module gpr_wb_arb #(
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input logic         clk_,
    input logic         reset,
    gpr_wb_arb_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SC_W  = $clog2(STARVE_MAX + 1);

    typedef enum logic {NORM, FORCE} state_t;

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic [SC_W-1:0]       sc_reg, sc_next;
    logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next, wr_ptr_reg, wr_ptr_next;
    logic [DEPTH-1:0]      vld_reg, vld_next, squash;
    logic [REG_ADDR_W-1:0] fifo_addr_reg [DEPTH];
    logic [DATA_W-1:0]     fifo_data_reg [DEPTH];
    logic                  we_reg, we_next;
    logic [REG_ADDR_W-1:0] wr_addr_reg, wr_addr_next;
    logic [DATA_W-1:0]     wr_data_reg, wr_data_next;

    logic is_force, full, nonempty, a_win, b_acc, direct_b, pop, push;

    assign is_force = (state_reg == FORCE);
    assign full     = (count_reg == CNT_W'(DEPTH));
    assign nonempty = (count_reg != '0);
    assign a_win    = !is_force && !bus.a_req_;
    assign b_acc    = !bus.b_req_ && !full;
    assign pop      = nonempty && (is_force || !a_win);
    assign direct_b = !is_force && !a_win && !nonempty && b_acc;
    // A same-address B beside a winning A is older, so it is dropped outright.
    assign push     = b_acc && !direct_b && !(a_win && (bus.b_addr == bus.a_addr));

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign squash[gi]   = a_win && vld_reg[gi] && (fifo_addr_reg[gi] == bus.a_addr);
            assign vld_next[gi] = (vld_reg[gi] && !squash[gi] && !(pop && (rd_ptr_reg == PTR_W'(gi))))
                                  || (push && (wr_ptr_reg == PTR_W'(gi)));
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        sc_next      = sc_reg;
        count_next   = count_reg;
        rd_ptr_next  = rd_ptr_reg;
        wr_ptr_next  = wr_ptr_reg;
        we_next      = 1'b1;
        wr_addr_next = wr_addr_reg;
        wr_data_next = wr_data_reg;

        if (a_win) begin
            we_next      = 1'b0;
            wr_addr_next = bus.a_addr;
            wr_data_next = bus.a_data;
        end else if (pop) begin
            if (vld_reg[rd_ptr_reg]) begin
                we_next      = 1'b0;
                wr_addr_next = fifo_addr_reg[rd_ptr_reg];
                wr_data_next = fifo_data_reg[rd_ptr_reg];
            end
        end else if (direct_b) begin
            we_next      = 1'b0;
            wr_addr_next = bus.b_addr;
            wr_data_next = bus.b_data;
        end

        if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase

        if (pop)
            sc_next = '0;
        else if (a_win && nonempty)
            sc_next = sc_reg + SC_W'(1);

        case (state_reg)
            NORM: begin
                if (sc_next == SC_W'(STARVE_MAX))
                    state_next = FORCE;
            end
            FORCE: begin
                sc_next    = '0;
                state_next = NORM;
            end
            default: state_next = NORM;
        endcase
    end

    always_ff @(posedge clk_ or negedge reset) begin
        if (!reset) begin
            state_reg   <= NORM;
            count_reg   <= '0;
            sc_reg      <= '0;
            rd_ptr_reg  <= '0;
            wr_ptr_reg  <= '0;
            vld_reg     <= '0;
            we_reg      <= 1'b1;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            sc_reg      <= sc_next;
            rd_ptr_reg  <= rd_ptr_next;
            wr_ptr_reg  <= wr_ptr_next;
            vld_reg     <= vld_next;
            we_reg      <= we_next;
            wr_addr_reg <= wr_addr_next;
            wr_data_reg <= wr_data_next;
        end
    end

    // Payload needs no reset: nothing reads it unless the slot's valid bit is set.
    always_ff @(posedge clk_) begin
        if (push) begin
            fifo_addr_reg[wr_ptr_reg] <= bus.b_addr;
            fifo_data_reg[wr_ptr_reg] <= bus.b_data;
        end
    end

    logic              hit_0, hit_1;
    logic [DATA_W-1:0] data_0, data_1;
    logic [PTR_W-1:0]  slot;

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        hit_0  = 1'b0;
        hit_1  = 1'b0;
        data_0 = '0;
        data_1 = '0;
        slot   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = rd_ptr_reg + PTR_W'(k);
            if (vld_reg[slot] && (fifo_addr_reg[slot] == bus.rd_addr_0)) begin
                hit_0  = 1'b1;
                data_0 = fifo_data_reg[slot];
            end
            if (vld_reg[slot] && (fifo_addr_reg[slot] == bus.rd_addr_1)) begin
                hit_1  = 1'b1;
                data_1 = fifo_data_reg[slot];
            end
        end
    end

    assign bus.a_stall_   = !is_force;
    assign bus.b_stall_   = !full;
    assign bus.idle       = !nonempty && we_reg;
    assign bus.fwd_hit_0_ = !hit_0;
    assign bus.fwd_hit_1_ = !hit_1;
    assign bus.fwd_data_0 = data_0;
    assign bus.fwd_data_1 = data_1;
    assign bus.we_        = we_reg;
    assign bus.wr_addr    = wr_addr_reg;
    assign bus.wr_data    = wr_data_reg;
endmodule

// File: tb/tb_gpr_wb_arb.sv
// Directed bench for gpr_wb_arb: one table row per cycle (inputs plus outputs
// expected in that cycle), then hand sequences for reset behaviour.
module tb_gpr_wb_arb;
    logic clk_;
    logic reset;

    gpr_wb_arb_if #(.REG_ADDR_W(5), .DATA_W(32)) bus ();

    gpr_wb_arb #(
        .REG_ADDR_W(5),
        .DATA_W    (32),
        .DEPTH     (2),
        .STARVE_MAX(4)
    ) dut (
        .clk_ (clk_),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk_ = 1'b0;
        forever #5 clk_ = ~clk_;
    end

    typedef struct {
        int a_req_; int a_addr; int a_data;
        int b_req_; int b_addr; int b_data;
        int rd0;    int rd1;
        int we_;    int wa;     int wd;
        int as_;    int bs_;
        int h0_;    int f0;     int h1_; int f1;
        int idle;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input int row, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, got, exp);
        end else begin
            $display("ok   %s row %0d: %0h", name, row, got);
        end
    endtask

    task automatic drive(input int ar, input int aa, input int ad, input int br, input int ba, input int bd,
                         input int r0, input int r1);
        bus.a_req_    = ar[0];
        bus.a_addr    = aa[4:0];
        bus.a_data    = ad;
        bus.b_req_    = br[0];
        bus.b_addr    = ba[4:0];
        bus.b_data    = bd;
        bus.rd_addr_0 = r0[4:0];
        bus.rd_addr_1 = r1[4:0];
    endtask

    initial begin
        // a_req_ a_addr a_data | b_req_ b_addr b_data | rd0 rd1 || we_ wa wd | as_ bs_ | h0_ f0 | h1_ f1 | idle
        vecs.push_back('{0, 3,'h11, 1, 0,  0,   0, 0,  1, 0, 0,    1,1, 1,0,    1,0,    1}); // 0 first write after reset
        vecs.push_back('{0, 1,'h0A, 0, 2,'h0B,  2, 3,  0, 3,'h11,  1,1, 1,0,    1,0,    0}); // 1 collision
        vecs.push_back('{1, 0,  0,  1, 0,  0,   2, 1,  0, 1,'h0A,  1,1, 0,'h0B, 1,0,    0}); // 2 B queued, forwarded
        vecs.push_back('{1, 0,  0,  1, 0,  0,   2, 0,  0, 2,'h0B,  1,1, 1,0,    1,0,    0});
        vecs.push_back('{1, 0,  0,  1, 0,  0,   0, 0,  1, 2,'h0B,  1,1, 1,0,    1,0,    1});
        vecs.push_back('{1, 0,  0,  0, 7,'h77,  7, 0,  1, 2,'h0B,  1,1, 1,0,    1,0,    1}); // 5 direct B
        vecs.push_back('{1, 0,  0,  1, 0,  0,   7, 0,  0, 7,'h77,  1,1, 1,0,    1,0,    0});
        vecs.push_back('{1, 0,  0,  1, 0,  0,   0, 0,  1, 7,'h77,  1,1, 1,0,    1,0,    1});
        vecs.push_back('{0, 4,'h40, 0, 5,'h01,  5, 4,  1, 7,'h77,  1,1, 1,0,    1,0,    1}); // 8 B r5 queued
        vecs.push_back('{0, 5,'h02, 1, 0,  0,   5, 4,  0, 4,'h40,  1,1, 0,'h01, 1,0,    0}); // 9 A r5 squashes
        vecs.push_back('{1, 0,  0,  1, 0,  0,   5, 0,  0, 5,'h02,  1,1, 1,0,    1,0,    0}); // 10 invalid head popped
        vecs.push_back('{1, 0,  0,  1, 0,  0,   5, 0,  1, 5,'h02,  1,1, 1,0,    1,0,    1});
        vecs.push_back('{0, 6,'h66, 0, 6,'h99,  6, 0,  1, 5,'h02,  1,1, 1,0,    1,0,    1}); // 12 same-cycle squash
        vecs.push_back('{1, 0,  0,  1, 0,  0,   6, 0,  0, 6,'h66,  1,1, 1,0,    1,0,    0});
        vecs.push_back('{1, 0,  0,  1, 0,  0,   0, 0,  1, 6,'h66,  1,1, 1,0,    1,0,    1});
        vecs.push_back('{0, 8,'h80, 0, 9,'h90,  9,10,  1, 6,'h66,  1,1, 1,0,    1,0,    1}); // 15 fill + starve
        vecs.push_back('{0, 8,'h81, 0,10,'hA0,  9,10,  0, 8,'h80,  1,1, 0,'h90, 1,0,    0});
        vecs.push_back('{0, 8,'h82, 0,11,'hB0,  9,10,  0, 8,'h81,  1,0, 0,'h90, 0,'hA0, 0}); // 17 full
        vecs.push_back('{0, 8,'h83, 0,11,'hB0,  9,11,  0, 8,'h82,  1,0, 0,'h90, 1,0,    0});
        vecs.push_back('{0, 8,'h84, 0,11,'hB0,  9,10,  0, 8,'h83,  1,0, 0,'h90, 0,'hA0, 0});
        vecs.push_back('{0, 8,'h85, 0,11,'hB0,  9,10,  0, 8,'h84,  0,0, 0,'h90, 0,'hA0, 0}); // 20 forced cycle
        vecs.push_back('{0, 8,'h85, 0,11,'hB0,  9,10,  0, 9,'h90,  1,1, 1,0,    0,'hA0, 0}); // 21 third B accepted
        vecs.push_back('{1, 0,  0,  1, 0,  0,  11,10,  0, 8,'h85,  1,0, 0,'hB0, 0,'hA0, 0});
        vecs.push_back('{1, 0,  0,  1, 0,  0,  11,10,  0,10,'hA0,  1,1, 0,'hB0, 1,0,    0});
        vecs.push_back('{1, 0,  0,  1, 0,  0,  11, 0,  0,11,'hB0,  1,1, 1,0,    1,0,    0});
        vecs.push_back('{1, 0,  0,  1, 0,  0,   0, 0,  1,11,'hB0,  1,1, 1,0,    1,0,    1});
        vecs.push_back('{0, 1,'h10, 0,12,'hC1, 12, 0,  1,11,'hB0,  1,1, 1,0,    1,0,    1}); // 26 youngest match
        vecs.push_back('{0, 2,'h20, 0,12,'hC2, 12, 0,  0, 1,'h10,  1,1, 0,'hC1, 1,0,    0});
        vecs.push_back('{1, 0,  0,  1, 0,  0,  12, 0,  0, 2,'h20,  1,0, 0,'hC2, 1,0,    0});
        vecs.push_back('{1, 0,  0,  1, 0,  0,  12, 0,  0,12,'hC1,  1,1, 0,'hC2, 1,0,    0});
        vecs.push_back('{1, 0,  0,  1, 0,  0,   0, 0,  0,12,'hC2,  1,1, 1,0,    1,0,    0});
        vecs.push_back('{1, 0,  0,  1, 0,  0,   0, 0,  1,12,'hC2,  1,1, 1,0,    1,0,    1});
        vecs.push_back('{0,13,'hD0, 0,14,'hE0,  0, 0,  1,12,'hC2,  1,1, 1,0,    1,0,    1}); // 32 invalid head + B push
        vecs.push_back('{0,14,'hE1, 1, 0,  0,  14, 0,  0,13,'hD0,  1,1, 0,'hE0, 1,0,    0});
        vecs.push_back('{1, 0,  0,  0,15,'hF0, 15,14,  0,14,'hE1,  1,1, 1,0,    1,0,    0});
        vecs.push_back('{1, 0,  0,  1, 0,  0,  15, 0,  1,14,'hE1,  1,1, 0,'hF0, 1,0,    0});
        vecs.push_back('{1, 0,  0,  1, 0,  0,  15, 0,  0,15,'hF0,  1,1, 1,0,    1,0,    0});
        vecs.push_back('{1, 0,  0,  1, 0,  0,   0, 0,  1,15,'hF0,  1,1, 1,0,    1,0,    1});

        // Reset held with both requesters active.
        reset = 1'b0;
        drive(0, 3, 'h11, 0, 2, 'h22, 0, 0);
        repeat (2) @(negedge clk_);
        #1;
        check("rst_we_",       -1, 32'(bus.we_),        32'd1);
        check("rst_wr_addr",   -1, 32'(bus.wr_addr),    32'd0);
        check("rst_wr_data",   -1, bus.wr_data,         32'd0);
        check("rst_a_stall_",  -1, 32'(bus.a_stall_),   32'd1);
        check("rst_b_stall_",  -1, 32'(bus.b_stall_),   32'd1);
        check("rst_idle",      -1, 32'(bus.idle),       32'd1);
        check("rst_fwd_hit_0_",-1, 32'(bus.fwd_hit_0_), 32'd1);
        check("rst_fwd_data_0",-1, bus.fwd_data_0,      32'd0);
        check("rst_fwd_hit_1_",-1, 32'(bus.fwd_hit_1_), 32'd1);
        check("rst_fwd_data_1",-1, bus.fwd_data_1,      32'd0);

        @(negedge clk_);
        reset = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i].a_req_, vecs[i].a_addr, vecs[i].a_data,
                  vecs[i].b_req_, vecs[i].b_addr, vecs[i].b_data, vecs[i].rd0, vecs[i].rd1);
            #1;
            check("we_",        i, 32'(bus.we_),        32'(vecs[i].we_));
            check("wr_addr",    i, 32'(bus.wr_addr),    32'(vecs[i].wa));
            check("wr_data",    i, bus.wr_data,         32'(vecs[i].wd));
            check("a_stall_",   i, 32'(bus.a_stall_),   32'(vecs[i].as_));
            check("b_stall_",   i, 32'(bus.b_stall_),   32'(vecs[i].bs_));
            check("fwd_hit_0_", i, 32'(bus.fwd_hit_0_), 32'(vecs[i].h0_));
            check("fwd_data_0", i, bus.fwd_data_0,      32'(vecs[i].f0));
            check("fwd_hit_1_", i, 32'(bus.fwd_hit_1_), 32'(vecs[i].h1_));
            check("fwd_data_1", i, bus.fwd_data_1,      32'(vecs[i].f1));
            check("idle",       i, 32'(bus.idle),       32'(vecs[i].idle));
            @(negedge clk_);
        end

        // Reset mid-operation: a queued B write must vanish without being written.
        drive(0, 16, 'h55, 0, 17, 'h66, 17, 0);
        @(negedge clk_);
        drive(1, 0, 0, 1, 0, 0, 17, 0);
        #1;
        check("mid_pre_hit_0_", 100, 32'(bus.fwd_hit_0_), 32'd0);
        check("mid_pre_we_",    100, 32'(bus.we_),        32'd0);
        reset = 1'b0;
        #1;
        check("mid_we_",        101, 32'(bus.we_),        32'd1);
        check("mid_wr_addr",    101, 32'(bus.wr_addr),    32'd0);
        check("mid_wr_data",    101, bus.wr_data,         32'd0);
        check("mid_idle",       101, 32'(bus.idle),       32'd1);
        check("mid_fwd_hit_0_", 101, 32'(bus.fwd_hit_0_), 32'd1);
        check("mid_fwd_data_0", 101, bus.fwd_data_0,      32'd0);
        check("mid_a_stall_",   101, 32'(bus.a_stall_),   32'd1);
        check("mid_b_stall_",   101, 32'(bus.b_stall_),   32'd1);
        @(negedge clk_);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_);
            #1;
            check("post_rst_we_",  102 + c, 32'(bus.we_),  32'd1);
            check("post_rst_idle", 102 + c, 32'(bus.idle), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gpr_wb_arb.md
# gpr_wb_arb

Write-back arbiter that shares the single write port of the general-purpose register file between two requesters: port A (execute-stage result, high priority) and port B (load/memory return). Its registered outputs drive the register file's `we_`, `wr_addr` and `wr_data` directly. Port B writes that lose arbitration are held in a small FIFO, and a starvation limit stops port A from locking out port B. Two read-address compare ports report pending FIFO writes so the pipeline can forward or stall.

## Interface
- `REG_ADDR_W`, default 5: register address width.
- `DATA_W`, default 32: data width.
- `DEPTH`, default 2: port-B FIFO entries (power of two, ≥2).
- `STARVE_MAX`, default 4: consecutive A wins with a non-empty FIFO before B is forced.
- `clk_`, in, 1: clock. All state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `a_req_`, in, 1: A write request, active-low.
- `a_addr`, in, REG_ADDR_W: A destination.
- `a_data`, in, DATA_W: A data.
- `a_stall_`, out, 1: low means A is not accepted and must hold its request.
- `b_req_`, in, 1: B write request, active-low.
- `b_addr`, in, REG_ADDR_W: B destination.
- `b_data`, in, DATA_W: B data.
- `b_stall_`, out, 1: low means the FIFO is full; B is not accepted and must hold.
- `rd_addr_0`, `rd_addr_1`, in, REG_ADDR_W: read addresses to check against pending writes.
- `fwd_hit_0_`, `fwd_hit_1_`, out, 1: low means a valid FIFO entry targets `rd_addr_k`.
- `fwd_data_0`, `fwd_data_1`, out, DATA_W: data of the youngest matching entry; 0 when there is no hit.
- `we_`, out, 1: register-file write enable, active-low, registered.
- `wr_addr`, out, REG_ADDR_W: registered write address.
- `wr_data`, out, DATA_W: registered write data.
- `idle`, out, 1: high when the FIFO is empty and `we_` is high.

## Operation
- **State machine:** two states, NORM and FORCE. Reset enters NORM.
- **Counters:** FIFO count 0..DEPTH; starvation counter `sc`.
- **Each cycle in NORM**, exactly one winner is chosen, in priority order:
  1. A, if `a_req_` is low. A is never stalled in NORM.
  2. Otherwise the FIFO head.
  3. Otherwise a B request, passed directly (FIFO empty and A idle).
- **B acceptance:** B is accepted when `b_req_` is low and `b_stall_` is high.
  - An accepted B that is not the winner is pushed into the FIFO.
  - `b_stall_` is low exactly when count == DEPTH. It depends only on registered count, not on a same-cycle pop.
- **Age order:** a request arriving in a later cycle is younger. When A and B arrive in the same cycle, B is older.
- **Squash on A win:** when A wins with address X:
  - Every valid FIFO entry with address X is invalidated.
  - A same-cycle accepted B with address X is accepted but not pushed.
- **Invalid FIFO head:** when selected, it is popped with no write that cycle (`we_` high next cycle). In that cycle a B request is pushed, not passed directly.
- **Starvation counter:**
  - `sc` increments in each cycle A wins while the FIFO is non-empty.
  - `sc` clears on any pop.
  - When `sc` reaches STARVE_MAX, the next state is FORCE.
- **FORCE state:**
  - `a_stall_` is low, driven from registered state.
  - The head is popped and written, or discarded if invalid.
  - B may push.
  - Next state is NORM with `sc` = 0.
- **Forwarding:** a FIFO entry counts for forwarding only if it is valid. Compares cover valid FIFO entries only. The in-flight output register is covered by the register file's own bypass, and same-cycle incoming requests are not compared.
- **Simultaneous push and pop:** count is unchanged, and a push into a full FIFO is impossible because `b_stall_` is low.

## Timing
- Write latency: a winner in cycle n appears on `we_`/`wr_addr`/`wr_data` after the rising edge ending cycle n. The register file captures it at the falling edge within cycle n+1.
- No winner in a cycle means `we_` is high the next cycle. `wr_addr` and `wr_data` hold their last value.
- `a_stall_`, `b_stall_`, `idle` and `fwd_*` are combinational from registered state plus `rd_addr_k`. `fwd_*` are valid in the same cycle.
- Reset values (asynchronous, immediate):
  - `we_` = 1, `wr_addr` = 0, `wr_data` = 0.
  - `a_stall_` = 1, `b_stall_` = 1.
  - FIFO empty with all entries invalid, `sc` = 0, state NORM.
  - `idle` = 1, `fwd_hit_k_` = 1, `fwd_data_k` = 0.
- Reset mid-operation drops all pending FIFO writes with no write issued.
- Worst-case B latency is bounded: STARVE_MAX + DEPTH × (STARVE_MAX + 1) + 1 cycles.

## Test plan
- **Reset values:** assert `reset` low with requests active → all outputs at reset values. First rising edge after release with `a_req_` low, `a_addr`=3, `a_data`=0x11 → next cycle `we_`=0, `wr_addr`=3, `wr_data`=0x11.
- **Same-cycle collision:** A(r1,0xA) and B(r2,0xB) in the same cycle → r1 written in cycle n+1, r2 in cycle n+2. During cycle n+1, `fwd_hit_0_`=0 with `fwd_data_0`=0xB for `rd_addr_0`=2.
- **Squash:** B(r5,0x1) queued behind continuous A, then A(r5,0x2) wins → r5 written only with 0x2. The squashed head later yields one cycle with `we_`=1, and its forward hit disappears.
- **FIFO full:** A continuously requesting, two B pushes → `b_stall_`=0; a third B holds and is accepted once a pop frees space.
- **Starvation:** STARVE_MAX=4, FIFO non-empty, A requesting every cycle → after 4 A wins, one cycle with `a_stall_`=0 and the head written; then NORM.
- **Direct B:** A idle, FIFO empty, B(r7,0x77) → written the next cycle and never enters the FIFO. `idle` returns to 1 two cycles later.
